srt_div_controller: RTL and testbench
=====================================

SRT_DIV_CONTROLLER -- requirements
Module: srt_div_controller

Interface
REQ-001 Parameter N, default 8: operand width; sets iteration count and counter widths.
REQ-002 The clock and reset SHALL use one clock with synchronous active-high reset, ports named clk and rst.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request a division; sampled only in IDLE.
REQ-006 m_zero  in  1  divisor register equals zero; valid from the cycle after LOAD.
REQ-007 m_msb  in  1  divisor register MSB.
REQ-008 a_top3  in  3  partial remainder bits [N:N-2], sign first.
REQ-009 a_sign  in  1  partial remainder sign bit.
REQ-010 load_a, load_q, load_qp, load_m  out  1 each  register load strobes.
REQ-011 lshift_m, lshift_aq, lshift_qp, rshift_a  out  1 each  shift strobes.
REQ-012 q_entry, qp_entry  out  1 each  bits entering Q / QP on left shift.
REQ-013 add_m, sub_m  out  1 each  ALU add/subtract divisor into A; never both high.
REQ-014 q_minus_qp  out  1  datapath forms Q := Q + not QP + 1.
REQ-015 c_up_qp  out  1  increments QP for the correction step.
REQ-016 busy, done, dbz  out  1 each  in operation / result-valid pulse / divide-by-zero flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, NORM, ITER, QSUB, CHK, CORR, DENORM, DONE, ERR.
REQ-018 IDLE: busy=0; start=1 -> LOAD; start in any other state is ignored.
REQ-019 LOAD (1 cycle): load_a, load_q, load_qp, load_m=1; qp loads 0; k counter := 0; -> NORM.
REQ-020 NORM: if m_zero -> ERR; else if m_msb=0: lshift_m=1, lshift_aq=1, k:=k+1, stay; else -> ITER with iter counter := 0.
REQ-021 NORM lasts exactly k cycles of shifting, with k = leading zeros of the divisor (0..N-1).
REQ-022 ITER lasts exactly N cycles, each with lshift_aq=1 and lshift_qp=1.
REQ-023 Digit select on a_top3: 000 or 111 -> q_entry=0, qp_entry=0, no ALU op.
REQ-024 Digit select on a_top3: 0xx (other) -> q_entry=1, sub_m=1.
REQ-025 Digit select on a_top3: 1xx (other) -> qp_entry=1, add_m=1.
REQ-026 After the N-th ITER cycle -> QSUB (1 cycle, q_minus_qp=1) -> CHK (1 cycle, evaluates a_sign).
REQ-027 CHK: a_sign=1 -> CORR (1 cycle: add_m=1, c_up_qp=1, q_minus_qp=1 applied as Q-1); a_sign=0 -> DENORM.
REQ-028 DENORM: rshift_a=1 for exactly k cycles, decrementing k; k=0 on entry -> DONE directly.
REQ-029 DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
REQ-030 ERR: done=1 and dbz=1 for one cycle, no further datapath strobes, -> IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-032 Latency SHALL be start-to-done = 1 + k + N + 2 + c + k + 1 cycles, where c = 1 if corrected else 0.
REQ-033 Counters SHALL be ceil(log2(N))+1 bits wide and SHALL never wrap; the iteration counter saturates at N.
REQ-034 All strobes not named for the current state SHALL be 0; at most one shift strobe per register per cycle.

Reset
REQ-035 rst=1 at an edge SHALL force IDLE, zero both counters and drive all outputs to 0 the next cycle.
REQ-036 Reset mid-operation SHALL abort without emitting done or dbz; a start held through reset release SHALL be accepted on the first IDLE cycle.

Structure
REQ-037 Package srt_div_pkg SHALL hold the state enumeration, default N, and the digit codes (ZERO, POS, NEG).
REQ-038 Digit selection SHALL be a combinational sub-module srt_qdigit_sel (a_top3 in; q_entry, qp_entry, add_m, sub_m out).

Verification
REQ-039 The bench SHALL cover: divisor 8'b00000111 (m_msb after 5 shifts), no correction -> NORM exactly 5 cycles, ITER 8, DENORM 5, done at cycle 22 after start.
REQ-040 The bench SHALL cover: divisor 8'b10000000 -> NORM 0 shift cycles, DENORM skipped, done at cycle 12 (13 if a_sign=1 in CHK).
REQ-041 The bench SHALL cover: m_zero=1 after LOAD -> ERR, done=dbz=1 for one cycle at cycle 2, no ITER strobes.
REQ-042 The bench SHALL cover: a_top3 sequence 000,011,110,111 during ITER -> entries (0,0),(q,sub),(qp,add),(0,0) on those cycles.
REQ-043 The bench SHALL cover: rst asserted on ITER cycle 4 -> IDLE next cycle, all outputs 0, no done; a new start then completes normally.
REQ-044 The bench SHALL cover: start pulsed while busy -> ignored, latency unchanged, exactly one done pulse.

Source files
------------

// File: rtl/srt_div_pkg.sv
// Shared types for the radix-2 SRT divider controller: FSM states, default
// operand width and quotient-digit codes.
package srt_div_pkg;

  localparam int unsigned N_DEFAULT = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_NORM,
    S_ITER,
    S_QSUB,
    S_CHK,
    S_CORR,
    S_DENORM,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ZERO,
    POS,
    NEG
  } digit_t;

  // Top three remainder bits all equal means |A| is small enough to skip the ALU.
  function automatic digit_t qdigit(input logic [2:0] top3);
    if (top3 == 3'b000 || top3 == 3'b111) return ZERO;
    else if (!top3[2]) return POS;
    else return NEG;
  endfunction

endpackage

// File: rtl/srt_qdigit_sel.sv
// Combinational SRT quotient-digit selection from the top partial-remainder bits.
module srt_qdigit_sel
  import srt_div_pkg::*;
(
  input  logic [2:0] a_top3,
  output logic       q_entry,
  output logic       qp_entry,
  output logic       add_m,
  output logic       sub_m
);

  digit_t dig;

  always_comb begin
    dig      = qdigit(a_top3);
    q_entry  = (dig == POS);
    sub_m    = (dig == POS);
    qp_entry = (dig == NEG);
    add_m    = (dig == NEG);
  end

endmodule

// File: rtl/srt_div_controller.sv
// Control FSM for a radix-2 SRT divider: normalise, iterate, convert the
// redundant quotient, optionally correct, then denormalise the remainder.
module srt_div_controller
  import srt_div_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       m_zero,
  input  logic       m_msb,
  input  logic [2:0] a_top3,
  input  logic       a_sign,
  output logic       load_a,
  output logic       load_q,
  output logic       load_qp,
  output logic       load_m,
  output logic       lshift_m,
  output logic       lshift_aq,
  output logic       lshift_qp,
  output logic       rshift_a,
  output logic       q_entry,
  output logic       qp_entry,
  output logic       add_m,
  output logic       sub_m,
  output logic       q_minus_qp,
  output logic       c_up_qp,
  output logic       busy,
  output logic       done,
  output logic       dbz
);

  localparam int unsigned CW = $clog2(N) + 1;

  state_t          state;
  logic [CW-1:0]   k_cnt;
  logic [CW-1:0]   iter_cnt;
  logic            sel_q, sel_qp, sel_add, sel_sub;

  srt_qdigit_sel u_qdigit_sel (
    .a_top3   (a_top3),
    .q_entry  (sel_q),
    .qp_entry (sel_qp),
    .add_m    (sel_add),
    .sub_m    (sel_sub)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      k_cnt    <= '0;
      iter_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          k_cnt <= '0;
          state <= S_NORM;
        end
        S_NORM: begin
          if (m_zero) begin
            state <= S_ERR;
            busy  <= 1'b0;
            done  <= 1'b1;
            dbz   <= 1'b1;
          end else if (!m_msb) begin
            if (k_cnt != CW'(N - 1)) k_cnt <= k_cnt + 1'b1;
          end else begin
            iter_cnt <= '0;
            state    <= S_ITER;
          end
        end
        S_ITER: begin
          if (iter_cnt != CW'(N)) iter_cnt <= iter_cnt + 1'b1;
          if (iter_cnt == CW'(N - 1)) state <= S_QSUB;
        end
        S_QSUB: state <= S_CHK;
        S_CHK, S_CORR: begin
          // A negative remainder detours through one correction cycle first.
          if (state == S_CHK && a_sign) begin
            state <= S_CORR;
          end else if (k_cnt == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_DENORM;
          end
        end
        S_DENORM: begin
          if (k_cnt != '0) k_cnt <= k_cnt - 1'b1;
          if (k_cnt <= CW'(1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath strobes react to the datapath status bits in the same cycle.
  always_comb begin
    load_a     = 1'b0;
    load_q     = 1'b0;
    load_qp    = 1'b0;
    load_m     = 1'b0;
    lshift_m   = 1'b0;
    lshift_aq  = 1'b0;
    lshift_qp  = 1'b0;
    rshift_a   = 1'b0;
    q_entry    = 1'b0;
    qp_entry   = 1'b0;
    add_m      = 1'b0;
    sub_m      = 1'b0;
    q_minus_qp = 1'b0;
    c_up_qp    = 1'b0;
    case (state)
      S_LOAD: begin
        load_a  = 1'b1;
        load_q  = 1'b1;
        load_qp = 1'b1;
        load_m  = 1'b1;
      end
      S_NORM: begin
        if (!m_zero && !m_msb) begin
          lshift_m  = 1'b1;
          lshift_aq = 1'b1;
        end
      end
      S_ITER: begin
        lshift_aq = 1'b1;
        lshift_qp = 1'b1;
        q_entry   = sel_q;
        qp_entry  = sel_qp;
        add_m     = sel_add;
        sub_m     = sel_sub;
      end
      S_QSUB: q_minus_qp = 1'b1;
      S_CORR: begin
        add_m      = 1'b1;
        c_up_qp    = 1'b1;
        q_minus_qp = 1'b1;
      end
      S_DENORM: rshift_a = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_srt_div_controller.sv
// Bench for srt_div_controller: a shadow divisor register closes the
// normalisation loop, and a timeline model gives the expected outputs per cycle.
module tb_srt_div_controller;

  localparam int unsigned N = 8;
  localparam logic [2:0] DIR_SEQ [4] = '{3'b000, 3'b011, 3'b110, 3'b111};

  typedef struct packed {
    logic load_a, load_q, load_qp, load_m;
    logic lshift_m, lshift_aq, lshift_qp, rshift_a;
    logic q_entry, qp_entry, add_m, sub_m;
    logic q_minus_qp, c_up_qp;
    logic busy, done, dbz;
  } outs_t;

  logic clk = 1'b0;
  logic rst, start, m_zero, m_msb, a_sign;
  logic [2:0] a_top3;
  logic load_a, load_q, load_qp, load_m, lshift_m, lshift_aq, lshift_qp, rshift_a;
  logic q_entry, qp_entry, add_m, sub_m, q_minus_qp, c_up_qp, busy, done, dbz;
  logic [N-1:0] m_operand;
  logic [N-1:0] m_reg = '0;
  outs_t obs;

  int n_tests = 0;
  int n_fail  = 0;

  srt_div_controller #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .m_zero(m_zero), .m_msb(m_msb),
    .a_top3(a_top3), .a_sign(a_sign),
    .load_a(load_a), .load_q(load_q), .load_qp(load_qp), .load_m(load_m),
    .lshift_m(lshift_m), .lshift_aq(lshift_aq), .lshift_qp(lshift_qp), .rshift_a(rshift_a),
    .q_entry(q_entry), .qp_entry(qp_entry), .add_m(add_m), .sub_m(sub_m),
    .q_minus_qp(q_minus_qp), .c_up_qp(c_up_qp), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_m) m_reg <= m_operand;
    else if (lshift_m) m_reg <= m_reg << 1;
  end

  assign m_zero = (m_reg == '0);
  assign m_msb  = m_reg[N-1];
  assign obs = {load_a, load_q, load_qp, load_m, lshift_m, lshift_aq, lshift_qp, rshift_a,
                q_entry, qp_entry, add_m, sub_m, q_minus_qp, c_up_qp, busy, done, dbz};

  // Expected outputs j cycles after the edge that accepted start (j=0 is LOAD).
  function automatic outs_t expect_out(input bit err, input int k, input int c,
                                       input int j, input logic [2:0] a3);
    outs_t e;
    int it_lo, it_hi, lat;
    e = '0;
    it_lo = k + 2;
    it_hi = k + 1 + N;
    lat   = 4 + 2 * k + N + c;
    if (j == 0) begin
      e.load_a = 1; e.load_q = 1; e.load_qp = 1; e.load_m = 1; e.busy = 1;
    end else if (err) begin
      if (j == 1) e.busy = 1;
      else if (j == 2) begin e.done = 1; e.dbz = 1; end
    end else if (j <= k) begin
      e.lshift_m = 1; e.lshift_aq = 1; e.busy = 1;
    end else if (j < it_lo) begin
      e.busy = 1;
    end else if (j <= it_hi) begin
      e.lshift_aq = 1; e.lshift_qp = 1; e.busy = 1;
      if (a3 != 3'd0 && a3 != 3'd7) begin
        if (a3 < 3'd4) begin e.q_entry = 1; e.sub_m = 1; end
        else begin e.qp_entry = 1; e.add_m = 1; end
      end
    end else if (j == it_hi + 1) begin
      e.q_minus_qp = 1; e.busy = 1;
    end else if (j == it_hi + 2) begin
      e.busy = 1;
    end else if (c == 1 && j == it_hi + 3) begin
      e.add_m = 1; e.c_up_qp = 1; e.q_minus_qp = 1; e.busy = 1;
    end else if (j < lat) begin
      e.rshift_a = 1; e.busy = 1;
    end else if (j == lat) begin
      e.done = 1;
    end
    return e;
  endfunction

  task automatic run_div(input string name, input logic [N-1:0] d, input logic sgn,
                         input bit directed, input bit poke);
    int k, c, lat, n_done, done_at, it;
    bit err;
    logic [2:0] a3;
    outs_t e;
    k = 0;
    err = (d == '0);
    if (!err) while (k < N - 1 && !d[N-1-k]) k++;
    c = sgn ? 1 : 0;
    lat = err ? 2 : 4 + 2 * k + N + c;
    @(negedge clk);
    start = 1'b1; m_operand = d; a_sign = sgn;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    done_at = -1;
    for (int j = 0; j <= lat + 1; j++) begin
      @(negedge clk);
      it = j - (k + 2);
      if (directed && it >= 0 && it < 4) a3 = DIR_SEQ[it];
      else a3 = 3'($urandom_range(0, 7));
      a_top3 = a3;
      if (poke) start = (j == 7);
      #1;
      e = expect_out(err, k, c, j, a3);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s d=%b j=%0d got=%b exp=%b", name, d, j, obs, e);
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = j;
      end
    end
    start = 1'b0;
    n_tests++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL %s_done_count got=%0d exp=1", name, n_done);
    end
    n_tests++;
    if (done_at != lat) begin
      n_fail++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, done_at, lat);
    end
  endtask

  task automatic test_reset();
    outs_t e;
    rst = 1'b1; start = 1'b0; a_top3 = '0; a_sign = 1'b0; m_operand = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_idle got=%b exp=0", obs); end
    start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_start_ignored got=%b exp=0", obs); end
    rst = 1'b0;
    @(negedge clk);
    e = '0;
    e.load_a = 1; e.load_q = 1; e.load_qp = 1; e.load_m = 1; e.busy = 1;
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_release_start got=%b exp=%b", obs, e); end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_abort_load got=%b exp=0", obs); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; m_operand = 8'b1000_0000; a_sign = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    a_top3 = 3'b011;
    #1;
    n_tests++;
    if (lshift_aq !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_in_iter got=%b%b exp=11", lshift_aq, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs !== '0) begin n_fail++; $display("FAIL reset_mid_quiet i=%0d got=%b exp=0", i, obs); end
      @(negedge clk);
    end
    run_div("after_reset", 8'b0000_0111, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_div7();
    run_div("div7", 8'b0000_0111, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_div128();
    run_div("div128", 8'b1000_0000, 1'b0, 1'b0, 1'b0);
    run_div("div128_corr", 8'b1000_0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_dbz();
    run_div("dbz", 8'b0000_0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_digit_seq();
    run_div("digit_seq", 8'b0100_1101, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_div("busy_start", 8'b0000_0111, 1'b0, 1'b0, 1'b1);
    run_div("b2b", 8'b0010_0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] d;
    for (int i = 0; i < 16; i++) begin
      d = N'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) d = '0;
      run_div("random", d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_div7();
    test_div128();
    test_dbz();
    test_digit_seq();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
